mgmt_gpio_retimer: RTL and testbench

- Parametrised, registered successor to the flat management GPIO buffer array.
- Sits between the management core and the user-project I/O ring.
- Input path: configurable synchroniser plus a per-channel glitch filter with change-pulse flags.
- Output and output-enable path: configurable pipeline that holds pads safe (outputs disabled, driven 0) for a programmable hold-off after reset.

---
 rtl/mgmt_gpio_retimer.sv | 142 ++++++++++++++
 tb/tb_mgmt_gpio_retimer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mgmt_gpio_retimer.sv
// Registered management GPIO buffer: synchronised, glitch-filtered inputs and a
// pipelined out/oeb path that keeps pads safe until a post-reset hold-off expires.
module mgmt_gpio_retimer #(
    parameter int unsigned IN_WIDTH    = 38,
    parameter int unsigned OUT_WIDTH   = 38,
    parameter int unsigned OEB_WIDTH   = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CNT    = 3,
    parameter int unsigned OUT_STAGES  = 1,
    parameter int unsigned HOLDOFF     = 4
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 filt_en,
    input  logic [IN_WIDTH-1:0]  mgmt_gpio_in,
    output logic [IN_WIDTH-1:0]  mgmt_gpio_in_buf,
    output logic [IN_WIDTH-1:0]  in_change,
    input  logic [OUT_WIDTH-1:0] mgmt_gpio_out,
    output logic [OUT_WIDTH-1:0] mgmt_gpio_out_buf,
    input  logic [OEB_WIDTH-1:0] mgmt_gpio_oeb,
    output logic [OEB_WIDTH-1:0] mgmt_gpio_oeb_buf,
    output logic                 ready
);

    localparam logic [1:0] ST_RST  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [3:0] FILT_LAST = 4'(FILT_CNT - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF - 1);

    logic [SYNC_STAGES-1:0][IN_WIDTH-1:0] sync_q, sync_d;
    logic [IN_WIDTH-1:0]                  sync_s;
    logic [IN_WIDTH-1:0][3:0]             filt_cnt_q, filt_cnt_d;
    logic [IN_WIDTH-1:0]                  in_buf_q, in_buf_d;
    logic [IN_WIDTH-1:0]                  in_change_q, in_change_d;

    logic [OUT_STAGES-1:0][OUT_WIDTH-1:0] out_pipe_q, out_pipe_d;
    logic [OUT_STAGES-1:0][OEB_WIDTH-1:0] oeb_pipe_q, oeb_pipe_d;

    logic [1:0] state_q, state_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       ready_q, ready_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = mgmt_gpio_in;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // With filt_en low every differing sample is accepted at once and counters stay cleared.
    always_comb begin
        in_buf_d    = in_buf_q;
        in_change_d = '0;
        filt_cnt_d  = filt_cnt_q;
        for (int unsigned i = 0; i < IN_WIDTH; i++) begin
            if (sync_s[i] == in_buf_q[i]) begin
                filt_cnt_d[i] = '0;
            end else if (!filt_en || (filt_cnt_q[i] == FILT_LAST)) begin
                in_buf_d[i]    = sync_s[i];
                in_change_d[i] = 1'b1;
                filt_cnt_d[i]  = '0;
            end else begin
                filt_cnt_d[i] = filt_cnt_q[i] + 4'd1;
            end
            if (!filt_en) begin
                filt_cnt_d[i] = '0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_RST: begin
                hold_cnt_d = '0;
                state_d    = (HOLDOFF == 0) ? ST_RUN : ST_HOLD;
            end
            ST_HOLD: begin
                hold_cnt_d = hold_cnt_q + 8'd1;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_RST;
        endcase
        ready_d = (state_d == ST_RUN);
    end

    // Earlier stages always shift; only the pad-facing stage is forced safe until ready.
    always_comb begin
        out_pipe_d    = out_pipe_q;
        oeb_pipe_d    = oeb_pipe_q;
        out_pipe_d[0] = mgmt_gpio_out;
        oeb_pipe_d[0] = mgmt_gpio_oeb;
        for (int unsigned i = 1; i < OUT_STAGES; i++) begin
            out_pipe_d[i] = out_pipe_q[i-1];
            oeb_pipe_d[i] = oeb_pipe_q[i-1];
        end
        if (!ready_q) begin
            out_pipe_d[OUT_STAGES-1] = '0;
            oeb_pipe_d[OUT_STAGES-1] = '1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync_q      <= '0;
            filt_cnt_q  <= '0;
            in_buf_q    <= '0;
            in_change_q <= '0;
            out_pipe_q  <= '0;
            oeb_pipe_q  <= '1;
            state_q     <= ST_RST;
            hold_cnt_q  <= '0;
            ready_q     <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            filt_cnt_q  <= filt_cnt_d;
            in_buf_q    <= in_buf_d;
            in_change_q <= in_change_d;
            out_pipe_q  <= out_pipe_d;
            oeb_pipe_q  <= oeb_pipe_d;
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            ready_q     <= ready_d;
        end
    end

    assign mgmt_gpio_in_buf  = in_buf_q;
    assign in_change         = in_change_q;
    assign mgmt_gpio_out_buf = out_pipe_q[OUT_STAGES-1];
    assign mgmt_gpio_oeb_buf = oeb_pipe_q[OUT_STAGES-1];
    assign ready             = ready_q;

endmodule

// File: tb/tb_mgmt_gpio_retimer.sv
// Scoreboard bench for mgmt_gpio_retimer: default instance plus an OUT_STAGES=3 instance.
module tb_mgmt_gpio_retimer;

    typedef struct {
        logic        rdy;
        logic [37:0] out;
        logic [2:0]  oeb;
    } exp_out_t;

    typedef struct {
        logic [37:0] ib;
        logic [37:0] chg;
    } exp_in_t;

    logic        clock = 1'b0;
    logic        resetn;
    logic        filt_en;
    logic [37:0] gpio_in;
    logic [37:0] gpio_out;
    logic [2:0]  gpio_oeb;

    logic [37:0] in_buf1, chg1, out_buf1;
    logic [2:0]  oeb_buf1;
    logic        ready1;
    logic [37:0] in_buf3, chg3, out_buf3;
    logic [2:0]  oeb_buf3;
    logic        ready3;

    exp_out_t oq[$];
    exp_out_t oq3[$];
    exp_in_t  iq[$];

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mgmt_gpio_retimer dut1 (
        .clock(clock), .resetn(resetn), .filt_en(filt_en),
        .mgmt_gpio_in(gpio_in), .mgmt_gpio_in_buf(in_buf1), .in_change(chg1),
        .mgmt_gpio_out(gpio_out), .mgmt_gpio_out_buf(out_buf1),
        .mgmt_gpio_oeb(gpio_oeb), .mgmt_gpio_oeb_buf(oeb_buf1), .ready(ready1)
    );

    mgmt_gpio_retimer #(.OUT_STAGES(3)) dut3 (
        .clock(clock), .resetn(resetn), .filt_en(filt_en),
        .mgmt_gpio_in(gpio_in), .mgmt_gpio_in_buf(in_buf3), .in_change(chg3),
        .mgmt_gpio_out(gpio_out), .mgmt_gpio_out_buf(out_buf3),
        .mgmt_gpio_oeb(gpio_oeb), .mgmt_gpio_oeb_buf(oeb_buf3), .ready(ready3)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        exp_out_t e;
        resetn   = 1'b0;
        filt_en  = 1'b1;
        gpio_in  = '0;
        gpio_out = '1;
        gpio_oeb = '0;
        tick();
        tick();
        checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready1); end
        checks++; if (out_buf1 !== 38'h0) begin errors++; $display("FAIL reset_out got=%h exp=0", out_buf1); end
        checks++; if (oeb_buf1 !== 3'b111) begin errors++; $display("FAIL reset_oeb got=%b exp=111", oeb_buf1); end
        checks++; if (in_buf1 !== 38'h0) begin errors++; $display("FAIL reset_inbuf got=%h exp=0", in_buf1); end
        checks++; if (chg1 !== 38'h0) begin errors++; $display("FAIL reset_change got=%h exp=0", chg1); end
        resetn = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            e.rdy = (k >= 5);
            e.out = (k >= 6) ? '1 : '0;
            e.oeb = (k >= 6) ? 3'b000 : 3'b111;
            oq.push_back(e);
        end
        for (int k = 1; k <= 7; k++) begin
            tick();
            e = oq.pop_front();
            checks++; if (ready1 !== e.rdy) begin errors++; $display("FAIL holdoff_ready k=%0d got=%b exp=%b", k, ready1, e.rdy); end
            checks++; if (ready3 !== e.rdy) begin errors++; $display("FAIL holdoff_ready3 k=%0d got=%b exp=%b", k, ready3, e.rdy); end
            checks++; if (out_buf1 !== e.out) begin errors++; $display("FAIL holdoff_out k=%0d got=%h exp=%h", k, out_buf1, e.out); end
            checks++; if (oeb_buf1 !== e.oeb) begin errors++; $display("FAIL holdoff_oeb k=%0d got=%b exp=%b", k, oeb_buf1, e.oeb); end
        end
    endtask

    task automatic test_filter_step();
        exp_in_t     e;
        logic [37:0] one5;
        one5 = 38'd1 << 5;
        filt_en = 1'b1;
        for (int dir = 1; dir >= 0; dir--) begin
            gpio_in[5] = dir[0];
            for (int k = 1; k <= 8; k++) begin
                e.ib  = ((k >= 5) == (dir == 1)) ? one5 : '0;
                e.chg = (k == 5) ? one5 : '0;
                iq.push_back(e);
            end
            for (int k = 1; k <= 8; k++) begin
                tick();
                e = iq.pop_front();
                checks++; if (in_buf1 !== e.ib) begin errors++; $display("FAIL filt_step_buf dir=%0d k=%0d got=%h exp=%h", dir, k, in_buf1, e.ib); end
                checks++; if (chg1 !== e.chg) begin errors++; $display("FAIL filt_step_chg dir=%0d k=%0d got=%h exp=%h", dir, k, chg1, e.chg); end
            end
        end
    endtask

    task automatic test_glitch();
        exp_in_t e;
        filt_en = 1'b1;
        gpio_in = '0;
        tick();
        gpio_in[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            e.ib  = '0;
            e.chg = '0;
            iq.push_back(e);
        end
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 2) gpio_in[0] = 1'b0;
            e = iq.pop_front();
            checks++; if (in_buf1 !== e.ib) begin errors++; $display("FAIL glitch_rej_buf k=%0d got=%h exp=%h", k, in_buf1, e.ib); end
            checks++; if (chg1 !== e.chg) begin errors++; $display("FAIL glitch_rej_chg k=%0d got=%h exp=%h", k, chg1, e.chg); end
        end
        filt_en = 1'b0;
        tick();
        tick();
        gpio_in[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            e.ib  = (k == 3 || k == 4) ? 38'd1 : 38'd0;
            e.chg = (k == 3 || k == 5) ? 38'd1 : 38'd0;
            iq.push_back(e);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 2) gpio_in[0] = 1'b0;
            e = iq.pop_front();
            checks++; if (in_buf1 !== e.ib) begin errors++; $display("FAIL glitch_pass_buf k=%0d got=%h exp=%h", k, in_buf1, e.ib); end
            checks++; if (chg1 !== e.chg) begin errors++; $display("FAIL glitch_pass_chg k=%0d got=%h exp=%h", k, chg1, e.chg); end
        end
    endtask

    task automatic test_all_toggle();
        exp_in_t e;
        filt_en = 1'b0;
        for (int dir = 1; dir >= 0; dir--) begin
            gpio_in = (dir == 1) ? '1 : '0;
            for (int k = 1; k <= 5; k++) begin
                e.ib  = ((k >= 3) == (dir == 1)) ? '1 : '0;
                e.chg = (k == 3) ? '1 : '0;
                iq.push_back(e);
            end
            for (int k = 1; k <= 5; k++) begin
                tick();
                e = iq.pop_front();
                checks++; if (in_buf1 !== e.ib) begin errors++; $display("FAIL all_toggle_buf dir=%0d k=%0d got=%h exp=%h", dir, k, in_buf1, e.ib); end
                checks++; if (chg1 !== e.chg) begin errors++; $display("FAIL all_toggle_chg dir=%0d k=%0d got=%h exp=%h", dir, k, chg1, e.chg); end
            end
        end
    endtask

    task automatic test_traffic_reset();
        exp_out_t    e;
        exp_in_t     ei;
        logic [37:0] v;
        logic [2:0]  o;
        filt_en = 1'b0;
        gpio_in = '1;
        for (int k = 0; k < 4; k++) tick();
        for (int k = 1; k <= 8; k++) begin
            v = 38'({$urandom(), $urandom()});
            o = 3'($urandom());
            gpio_out = v;
            gpio_oeb = o;
            e.rdy = 1'b1; e.out = v; e.oeb = o;
            oq.push_back(e);
            tick();
            e = oq.pop_front();
            checks++; if (out_buf1 !== e.out) begin errors++; $display("FAIL traffic_out k=%0d got=%h exp=%h", k, out_buf1, e.out); end
            checks++; if (oeb_buf1 !== e.oeb) begin errors++; $display("FAIL traffic_oeb k=%0d got=%b exp=%b", k, oeb_buf1, e.oeb); end
        end
        resetn = 1'b0;
        tick();
        checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL midreset_ready got=%b exp=0", ready1); end
        checks++; if (out_buf1 !== 38'h0) begin errors++; $display("FAIL midreset_out got=%h exp=0", out_buf1); end
        checks++; if (oeb_buf1 !== 3'b111) begin errors++; $display("FAIL midreset_oeb got=%b exp=111", oeb_buf1); end
        checks++; if (in_buf1 !== 38'h0) begin errors++; $display("FAIL midreset_inbuf got=%h exp=0", in_buf1); end
        checks++; if (chg1 !== 38'h0) begin errors++; $display("FAIL midreset_chg got=%h exp=0", chg1); end
        resetn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            v = 38'({$urandom(), $urandom()});
            o = 3'($urandom());
            gpio_out = v;
            gpio_oeb = o;
            e.rdy = (k >= 5);
            e.out = (k >= 6) ? v : '0;
            e.oeb = (k >= 6) ? o : 3'b111;
            oq.push_back(e);
            ei.ib  = (k >= 3) ? '1 : '0;
            ei.chg = (k == 3) ? '1 : '0;
            iq.push_back(ei);
            tick();
            e  = oq.pop_front();
            ei = iq.pop_front();
            checks++; if (ready1 !== e.rdy) begin errors++; $display("FAIL rehold_ready k=%0d got=%b exp=%b", k, ready1, e.rdy); end
            checks++; if (out_buf1 !== e.out) begin errors++; $display("FAIL rehold_out k=%0d got=%h exp=%h", k, out_buf1, e.out); end
            checks++; if (oeb_buf1 !== e.oeb) begin errors++; $display("FAIL rehold_oeb k=%0d got=%b exp=%b", k, oeb_buf1, e.oeb); end
            checks++; if (in_buf1 !== ei.ib) begin errors++; $display("FAIL rehold_inbuf k=%0d got=%h exp=%h", k, in_buf1, ei.ib); end
            checks++; if (chg1 !== ei.chg) begin errors++; $display("FAIL rehold_chg k=%0d got=%h exp=%h", k, chg1, ei.chg); end
        end
    endtask

    task automatic test_out_stages();
        exp_out_t e1, e3;
        gpio_out = '0;
        gpio_oeb = '0;
        for (int k = 0; k < 5; k++) tick();
        gpio_out = 38'hA5;
        for (int k = 1; k <= 6; k++) begin
            e1.rdy = 1'b1; e1.oeb = 3'b000; e1.out = (k == 1) ? 38'hA5 : 38'h0;
            e3.rdy = 1'b1; e3.oeb = 3'b000; e3.out = (k == 3) ? 38'hA5 : 38'h0;
            oq.push_back(e1);
            oq3.push_back(e3);
        end
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) gpio_out = '0;
            e1 = oq.pop_front();
            e3 = oq3.pop_front();
            checks++; if (out_buf1 !== e1.out) begin errors++; $display("FAIL stages1_out k=%0d got=%h exp=%h", k, out_buf1, e1.out); end
            checks++; if (out_buf3 !== e3.out) begin errors++; $display("FAIL stages3_out k=%0d got=%h exp=%h", k, out_buf3, e3.out); end
            checks++; if (oeb_buf3 !== e3.oeb) begin errors++; $display("FAIL stages3_oeb k=%0d got=%b exp=%b", k, oeb_buf3, e3.oeb); end
            checks++; if (ready3 !== e3.rdy) begin errors++; $display("FAIL stages3_ready k=%0d got=%b exp=%b", k, ready3, e3.rdy); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_filter_step();
        test_glitch();
        test_all_toggle();
        test_traffic_reset();
        test_out_stages();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
